// File: rtl/led_pkg.sv
// led_pkg: mode encodings and FSM states shared by the LED pattern shifter.
// Rev 1.0
`default_nettype none

package led_pkg;

  localparam logic [1:0] MODE_ROT_L    = 2'd0;
  localparam logic [1:0] MODE_ROT_R    = 2'd1;
  localparam logic [1:0] MODE_PINGPONG = 2'd2;
  localparam logic [1:0] MODE_FILL     = 2'd3;

  typedef enum logic [2:0] {
    ROT_L   = 3'd0,
    ROT_R   = 3'd1,
    PP_UP   = 3'd2,
    PP_DOWN = 3'd3,
    FILL    = 3'd4,
    DRAIN   = 3'd5
  } state_t;

endpackage

`default_nettype wire

// File: rtl/step_edge_detect.sv
// step_edge_detect: 1-bit rising-edge detector; edges seen while disabled are dropped.
// Rev 1.0
`default_nettype none

module step_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  input  logic level,
  output logic pulse
);

  logic level_d;

  // Tracks the input even while disabled so an edge cannot be replayed later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) level_d <= 1'b0;
    else     level_d <= level;
  end

  assign pulse = level & ~level_d & enable;

endmodule

`default_nettype wire

// File: rtl/led_pattern_shifter.sv
// led_pattern_shifter: steps a WIDTH-bit LED bank through rotate/ping-pong/fill patterns.
// Rev 1.0 -- LED_ACTIVE_LOW_EN inverts the leds port.
`default_nettype none

module led_pattern_shifter
  import led_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_100M,
  input  logic             rst,
  input  logic             enable,
  input  logic             step_in,
  input  logic [1:0]       mode,
  output logic [WIDTH-1:0] leds,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] PAT_ONE  = WIDTH'(1);
  localparam logic [WIDTH-1:0] PAT_MSB  = PAT_ONE << (WIDTH - 1);
  localparam logic [WIDTH-1:0] PAT_FULL = '1;

  logic             step;
  state_t           state_q, state_n;
  logic [WIDTH-1:0] pattern_q, pattern_n;
  logic [1:0]       applied_mode_q, applied_mode_n;
  logic             wrap_q, wrap_n;

  step_edge_detect u_step (
    .clk    (clk_100M),
    .rst    (rst),
    .enable (enable),
    .level  (step_in),
    .pulse  (step)
  );

  always_ff @(posedge clk_100M or posedge rst) begin
    if (rst) begin
      state_q        <= ROT_L;
      pattern_q      <= PAT_ONE;
      applied_mode_q <= MODE_ROT_L;
      wrap_q         <= 1'b0;
    end else begin
      state_q        <= state_n;
      pattern_q      <= pattern_n;
      applied_mode_q <= applied_mode_n;
      wrap_q         <= wrap_n;
    end
  end

  always_comb begin
    state_n        = state_q;
    pattern_n      = pattern_q;
    applied_mode_n = applied_mode_q;
    wrap_n         = 1'b0;
    if (step) begin
      if (mode != applied_mode_q) begin
        // A mode change spends its step on loading the start pattern.
        applied_mode_n = mode;
        case (mode)
          MODE_ROT_R:    begin pattern_n = PAT_MSB; state_n = ROT_R; end
          MODE_PINGPONG: begin pattern_n = PAT_ONE; state_n = PP_UP; end
          MODE_FILL:     begin pattern_n = PAT_ONE; state_n = FILL;  end
          default:       begin pattern_n = PAT_ONE; state_n = ROT_L; end
        endcase
      end else begin
        case (state_q)
          ROT_L: begin
            pattern_n = {pattern_q[WIDTH-2:0], pattern_q[WIDTH-1]};
            wrap_n    = (pattern_n == PAT_ONE);
          end
          ROT_R: begin
            pattern_n = {pattern_q[0], pattern_q[WIDTH-1:1]};
            wrap_n    = (pattern_n == PAT_MSB);
          end
          PP_UP: begin
            pattern_n = pattern_q << 1;
            if (pattern_n[WIDTH-1]) state_n = PP_DOWN;
          end
          PP_DOWN: begin
            pattern_n = pattern_q >> 1;
            if (pattern_n == PAT_ONE) begin
              state_n = PP_UP;
              wrap_n  = 1'b1;
            end
          end
          FILL: begin
            pattern_n = (pattern_q << 1) | PAT_ONE;
            if (pattern_n == PAT_FULL) state_n = DRAIN;
          end
          DRAIN: begin
            pattern_n = pattern_q << 1;
            if (pattern_n == '0) begin
              state_n = FILL;
              wrap_n  = 1'b1;
            end
          end
          default: begin
            state_n   = ROT_L;
            pattern_n = PAT_ONE;
          end
        endcase
      end
    end
  end

`ifdef LED_ACTIVE_LOW_EN
  assign leds = ~pattern_q;
`else
  assign leds = pattern_q;
`endif
  assign wrap = wrap_q;

endmodule

`default_nettype wire

// File: tb/tb_led_pattern_shifter.sv
// tb_led_pattern_shifter: scoreboard bench for led_pattern_shifter (WIDTH = 8).
// Rev 1.0
`default_nettype none

module tb_led_pattern_shifter;

  localparam int WIDTH = 8;

  logic             clk_100M = 1'b0;
  logic             rst      = 1'b1;
  logic             enable   = 1'b0;
  logic             step_in  = 1'b0;
  logic [1:0]       mode     = 2'd0;
  logic [WIDTH-1:0] leds;
  logic             wrap;

  always #5 clk_100M = ~clk_100M;

  led_pattern_shifter #(.WIDTH(WIDTH)) dut (
    .clk_100M (clk_100M),
    .rst      (rst),
    .enable   (enable),
    .step_in  (step_in),
    .mode     (mode),
    .leds     (leds),
    .wrap     (wrap)
  );

  typedef struct {
    int          due;
    logic [7:0]  pat;
    logic        wr;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc   = 0;

  // Hand-computed pattern sequences (internal pattern, active-high view).
  logic [7:0] rotl_v [9]  = '{8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h01, 8'h02};
  logic [7:0] pp_v   [16] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80,
                              8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h02};
  logic [7:0] fill_v [17] = '{8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF, 8'hFE,
                              8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00, 8'h01};
  logic [7:0] pp2_v  [10] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h40, 8'h20};
  logic [7:0] rotr_v [9]  = '{8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02, 8'h01, 8'h80};

  always @(posedge clk_100M) cyc <= cyc + 1;

  function automatic logic [7:0] pol(input logic [7:0] p);
`ifdef LED_ACTIVE_LOW_EN
    return ~p;
`else
    return p;
`endif
  endfunction

  function automatic void check(input string name, input logic [7:0] act_l, input logic act_w,
                                input logic [7:0] exp_l, input logic exp_w);
    n_cmp++;
    if (act_l !== exp_l || act_w !== exp_w) begin
      n_bad++;
      $display("FAIL %s: got leds=%h wrap=%b, required leds=%h wrap=%b",
               name, act_l, act_w, exp_l, exp_w);
    end
  endfunction

  task automatic push(input string name, input int off, input logic [7:0] p, input logic w);
    exp_t e;
    e.due  = cyc + off;
    e.pat  = p;
    e.wr   = w;
    e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compares every expectation that falls due on this sampling edge.
  always @(negedge clk_100M) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.due < cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL %s: expectation due at cycle %0d never sampled (now %0d)", e.name, e.due, cyc);
      end else begin
        check(e.name, leds, wrap, pol(e.pat), e.wr);
      end
    end
  end

  // One rising edge on step_in; result visible after the next posedge, wrap gone one cycle later.
  task automatic do_step(input string name, input logic [7:0] p, input logic w);
    @(negedge clk_100M);
    step_in = 1'b1;
    push(name, 1, p, w);
    push({name, "_after"}, 2, p, 1'b0);
    @(negedge clk_100M);
    step_in = 1'b0;
    @(negedge clk_100M);
  endtask

  task automatic do_reset(input string name);
    @(negedge clk_100M);
    rst     = 1'b1;
    step_in = 1'b0;
    @(negedge clk_100M);
    check(name, leds, wrap, pol(8'h01), 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk_100M);
    check("reset", leds, wrap, pol(8'h01), 1'b0);
    rst    = 1'b0;
    enable = 1'b1;

    mode = 2'd0;
    for (int i = 0; i < 9; i++)
      do_step($sformatf("rotl_%0d", i), rotl_v[i], i == 7);

    do_reset("reset_pp");
    mode = 2'd2;
    for (int i = 0; i < 16; i++)
      do_step($sformatf("pp_%0d", i), pp_v[i], i == 14);

    mode = 2'd3;
    for (int i = 0; i < 17; i++)
      do_step($sformatf("fill_%0d", i), fill_v[i], i == 15);

    enable = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_100M);
      step_in = 1'b1;
      push($sformatf("dis_hi_%0d", i), 1, 8'h01, 1'b0);
      @(negedge clk_100M);
      step_in = 1'b0;
      push($sformatf("dis_lo_%0d", i), 1, 8'h01, 1'b0);
    end
    @(negedge clk_100M);
    step_in = 1'b1;
    push("dis_last", 1, 8'h01, 1'b0);
    @(negedge clk_100M);
    enable = 1'b1;
    push("en_no_edge", 1, 8'h01, 1'b0);
    @(negedge clk_100M);
    push("en_hold", 1, 8'h01, 1'b0);
    step_in = 1'b0;
    do_step("en_advance", 8'h03, 1'b0);

    mode = 2'd2;
    for (int i = 0; i < 10; i++)
      do_step($sformatf("pp2_%0d", i), pp2_v[i], 1'b0);
    @(negedge clk_100M);
    #2;
    rst = 1'b1;
    #1;
    check("async_rst", leds, wrap, pol(8'h01), 1'b0);
    rst = 1'b0;
    do_step("post_rst_reload", 8'h01, 1'b0);
    do_step("post_rst_step", 8'h02, 1'b0);

    do_reset("reset_rotr");
    mode = 2'd1;
    for (int i = 0; i < 9; i++)
      do_step($sformatf("rotr_%0d", i), rotr_v[i], i == 8);

    for (int i = 0; i < 20 && sb.size() > 0; i++) @(negedge clk_100M);
    while (sb.size() > 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL %s: expectation still pending at end of run", sb[0].name);
      void'(sb.pop_front());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
